// File: rtl/ising_axil_bridge.sv
// ising_axil_bridge
// AXI4-Lite slave front-end for the Ising machine wrapper. Terminates the five
// AXI4-Lite channels and converts them into a one-cycle read request with a
// registered read return, and a one-cycle write strobe. Reads outside the spin
// phase window and writes to illegal addresses, or writes with partial strobes,
// are answered with SLVERR and never reach the core.
//
// Ports
//   clk, axi_rstn            clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*          AXI4-Lite write address / data / response
//   s_ar*/s_r*               AXI4-Lite read address / data
//   arvalid_q, araddr_q      one-cycle read request to the core (word aligned)
//   rready, rvalid, rresp,
//   rdata                    core read return handshake
//   wready, wr_addr, wdata   one-cycle write strobe to the core
//
// Read FSM
//   state   | meaning
//   R_IDLE  | accept AR, drain any stale core return
//   R_ISSUE | arvalid_q pulse to the core
//   R_WAIT  | wait for core return or timeout
//   R_RESP  | hold R channel until s_rready
// Write FSM
//   state   | meaning
//   W_IDLE  | capture AW and W independently, check once both held
//   W_ISSUE | wready pulse to the core
//   W_RESP  | hold B channel until s_bready
module ising_axil_bridge #(
   parameter int N          = 3,
   parameter int RD_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        axi_rstn,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_awaddr,
   input  logic        s_wvalid,
   output logic        s_wready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   output logic        s_bvalid,
   input  logic        s_bready,
   output logic [1:0]  s_bresp,
   input  logic        s_arvalid,
   output logic        s_arready,
   input  logic [31:0] s_araddr,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        arvalid_q,
   output logic [31:0] araddr_q,
   output logic        rready,
   input  logic        rvalid,
   input  logic        rresp,
   input  logic [31:0] rdata,
   output logic        wready,
   output logic [31:0] wr_addr,
   output logic [31:0] wdata
);

   localparam logic [31:0] WIN_LO = 32'h0000_0800;
   localparam logic [31:0] WIN_HI = 32'h0000_0800 + 32'(4 * N) - 32'd1;
   localparam int          CW     = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LOAD = CW'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_t;

   rd_state_t     rd_state;
   logic [CW-1:0] tmo_cnt;
   logic          ar_hs;
   logic [31:0]   ar_aligned;
   logic          ar_in_win;

   assign ar_hs      = s_arvalid & s_arready;
   assign ar_aligned = {s_araddr[31:2], 2'b00};
   assign ar_in_win  = (ar_aligned >= WIN_LO) && (ar_aligned <= WIN_HI);

   // Timeout is a down-counter: RD_TIMEOUT cycles in R_WAIT, the last one at zero.
   always_ff @(posedge clk) begin
      if (!axi_rstn) begin
         rd_state  <= R_IDLE;
         tmo_cnt   <= '0;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rdata   <= '0;
         s_rresp   <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         rready    <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               s_arready <= 1'b1;
               rready    <= 1'b1;
               if (ar_hs) begin
                  s_arready <= 1'b0;
                  rready    <= 1'b0;
                  if (ar_in_win) begin
                     araddr_q  <= ar_aligned;
                     arvalid_q <= 1'b1;
                     rd_state  <= R_ISSUE;
                  end else begin
                     s_rvalid <= 1'b1;
                     s_rdata  <= '0;
                     s_rresp  <= 2'b10;
                     rd_state <= R_RESP;
                  end
               end
            end
            R_ISSUE: begin
               arvalid_q <= 1'b0;
               rready    <= 1'b1;
               tmo_cnt   <= TMO_LOAD;
               rd_state  <= R_WAIT;
            end
            R_WAIT: begin
               // A return arriving on the terminal cycle still wins over the timeout.
               if (rvalid) begin
                  s_rvalid <= 1'b1;
                  s_rdata  <= rdata;
                  s_rresp  <= {rresp, 1'b0};
                  rready   <= 1'b0;
                  rd_state <= R_RESP;
               end else if (tmo_cnt == '0) begin
                  s_rvalid <= 1'b1;
                  s_rdata  <= '0;
                  s_rresp  <= 2'b10;
                  rready   <= 1'b0;
                  rd_state <= R_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            R_RESP: begin
               if (s_rready) begin
                  s_rvalid  <= 1'b0;
                  s_arready <= 1'b1;
                  rready    <= 1'b1;
                  rd_state  <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   wr_state_t   wr_state;
   logic        aw_held, w_held;
   logic [3:0]  wstrb_q;
   logic        aw_hs, w_hs, aw_have, w_have;
   logic [31:0] addr_now;
   logic [3:0]  strb_now;
   logic        wr_ok;

   assign aw_hs    = s_awvalid & s_awready;
   assign w_hs     = s_wvalid & s_wready;
   assign aw_have  = aw_held | aw_hs;
   assign w_have   = w_held | w_hs;
   // Check uses values arriving this cycle so the strobe follows the last capture directly.
   assign addr_now = aw_hs ? s_awaddr : wr_addr;
   assign strb_now = w_hs ? s_wstrb : wstrb_q;
   assign wr_ok    = (strb_now == 4'hF) &&
                     ((addr_now == 32'h500) || (addr_now == 32'h600) ||
                      (addr_now == 32'h700) || (addr_now >= 32'h1000));

   always_ff @(posedge clk) begin
      if (!axi_rstn) begin
         wr_state  <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         wstrb_q   <= '0;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= '0;
         wready    <= 1'b0;
         wr_addr   <= '0;
         wdata     <= '0;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_hs) begin
                  wr_addr <= s_awaddr;
                  aw_held <= 1'b1;
               end
               if (w_hs) begin
                  wdata   <= s_wdata;
                  wstrb_q <= s_wstrb;
                  w_held  <= 1'b1;
               end
               s_awready <= !aw_have;
               s_wready  <= !w_have;
               if (aw_have && w_have) begin
                  if (wr_ok) begin
                     wready   <= 1'b1;
                     wr_state <= W_ISSUE;
                  end else begin
                     s_bvalid <= 1'b1;
                     s_bresp  <= 2'b10;
                     wr_state <= W_RESP;
                  end
               end
            end
            W_ISSUE: begin
               wready   <= 1'b0;
               s_bvalid <= 1'b1;
               s_bresp  <= 2'b00;
               wr_state <= W_RESP;
            end
            W_RESP: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
                  s_awready <= 1'b1;
                  s_wready  <= 1'b1;
                  wr_state  <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ising_axil_bridge.sv
// Testbench for ising_axil_bridge: table of directed vectors, hand-written
// reset/backpressure/concurrency sequences, and randomized traffic checked
// against a rule-level model of the bridge plus a simple core responder.
module tb_ising_axil_bridge;

   localparam int N          = 3;
   localparam int RD_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        axi_rstn = 1'b0;
   logic        s_awvalid = 1'b0, s_awready;
   logic [31:0] s_awaddr = '0;
   logic        s_wvalid = 1'b0, s_wready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_bvalid, s_bready = 1'b0;
   logic [1:0]  s_bresp;
   logic        s_arvalid = 1'b0, s_arready;
   logic [31:0] s_araddr = '0;
   logic        s_rvalid, s_rready = 1'b0;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        arvalid_q;
   logic [31:0] araddr_q;
   logic        rready;
   logic        rvalid = 1'b0;
   logic        rresp = 1'b0;
   logic [31:0] rdata = '0;
   logic        wready;
   logic [31:0] wr_addr, wdata;

   ising_axil_bridge #(.N(N), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .clk(clk), .axi_rstn(axi_rstn),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
      .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
      .wready(wready), .wr_addr(wr_addr), .wdata(wdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Core responder: answers a request core_delay cycles later (0 = never),
   // holding rvalid until the bridge takes it.
   int          core_delay = 1;
   bit          core_err = 1'b0;
   int          pend = 0;
   logic [31:0] salt = 32'h0;

   function automatic logic [31:0] core_fn(logic [31:0] a);
      return {a[15:0], 16'h0000} ^ 32'h3C3C_A5A5 ^ salt;
   endfunction

   always @(posedge clk) begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (pend != 0) begin
         pend <= pend - 1;
         if (pend == 1) rvalid <= 1'b1;
      end
      if (arvalid_q && core_delay != 0) begin
         pend  <= core_delay - 1;
         rdata <= core_fn(araddr_q);
         rresp <= core_err;
         if (core_delay == 1) rvalid <= 1'b1;
      end
   end

   // Rule-level reference model
   function automatic void rd_model(input logic [31:0] a, input int dly, input bit err,
                                    output logic [1:0] resp, output logic [31:0] data,
                                    output int lat, output int pulses);
      logic [31:0] al;
      al = a & ~32'h3;
      if (al < 32'h800 || al >= 32'h800 + 4 * N) begin
         resp = 2'b10; data = '0; lat = 1; pulses = 0;
      end else begin
         pulses = 1;
         if (dly >= 1 && dly <= RD_TIMEOUT) begin
            resp = {err, 1'b0}; data = core_fn(al); lat = dly + 2;
         end else begin
            resp = 2'b10; data = '0; lat = RD_TIMEOUT + 2;
         end
      end
   endfunction

   function automatic bit wr_valid(logic [31:0] a, logic [3:0] s);
      return (s == 4'hF) && ((a inside {32'h500, 32'h600, 32'h700}) || a >= 32'h1000);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((pend != 0 || rvalid) && g < 40) begin
         step();
         g++;
      end
      if (g >= 40) chk("core_drain", 32'(rvalid), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int bp,
                          output logic [1:0] resp, output logic [31:0] data,
                          output int lat, output int pulses, output logic [31:0] seen);
      int g;
      resp = '0; data = '0; lat = 0; pulses = 0; seen = '0;
      s_araddr = addr;
      s_arvalid = 1'b1;
      g = 0;
      while (!s_arready && g < 50) begin step(); g++; end
      if (!s_arready) begin
         chk("ar_accept", 32'(s_arready), 32'd1);
         s_arvalid = 1'b0;
         return;
      end
      step();
      s_arvalid = 1'b0;
      lat = 1;
      while (!s_rvalid && lat < 60) begin
         if (arvalid_q) begin pulses++; seen = araddr_q; end
         step();
         lat++;
      end
      if (arvalid_q) pulses++;
      if (!s_rvalid) begin
         chk("r_valid_wait", 32'(s_rvalid), 32'd1);
         return;
      end
      resp = s_rresp;
      data = s_rdata;
      for (int k = 0; k < bp; k++) begin
         step();
         chk("r_hold_data", s_rdata, data);
         chk("r_hold_resp", 32'(s_rresp), 32'(resp));
         chk("r_hold_flags", {30'd0, s_rvalid, s_arready}, 32'b10);
      end
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      chk("r_release", {30'd0, s_rvalid, s_arready}, 32'b01);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int gap, input int bp,
                           output logic [1:0] resp, output int lat, output int pulses,
                           output logic [31:0] seen_a, output logic [31:0] seen_d);
      resp = '0; lat = 0; pulses = 0; seen_a = '0; seen_d = '0;
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      if (gap > 0) begin
         s_wvalid = 1'b1;
         step();
         s_wvalid = 1'b0;
         chk("w_ready_drop", 32'(s_wready), 32'd0);
         repeat (gap - 1) step();
         s_awvalid = 1'b1;
         step();
         s_awvalid = 1'b0;
      end else if (gap < 0) begin
         s_awvalid = 1'b1;
         step();
         s_awvalid = 1'b0;
         chk("aw_ready_drop", 32'(s_awready), 32'd0);
         repeat (-gap - 1) step();
         s_wvalid = 1'b1;
         step();
         s_wvalid = 1'b0;
      end else begin
         s_awvalid = 1'b1;
         s_wvalid = 1'b1;
         step();
         s_awvalid = 1'b0;
         s_wvalid = 1'b0;
      end
      lat = 1;
      while (!s_bvalid && lat < 10) begin
         if (wready) begin pulses++; seen_a = wr_addr; seen_d = wdata; end
         step();
         lat++;
      end
      if (wready) pulses++;
      if (!s_bvalid) begin
         chk("b_valid_wait", 32'(s_bvalid), 32'd1);
         return;
      end
      resp = s_bresp;
      for (int k = 0; k < bp; k++) begin
         step();
         chk("b_hold_resp", 32'(s_bresp), 32'(resp));
         chk("b_hold_flags", {29'd0, s_bvalid, s_awready, s_wready}, 32'b100);
      end
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("b_release", {29'd0, s_bvalid, s_awready, s_wready}, 32'b011);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          gap;
      int          dly;
      bit          err;
      logic [1:0]  exp_resp;
      int          exp_lat;
      int          exp_pulses;
      bit          use_core;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [31:0] all_outputs_or();
      return 32'(|{s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata,
                   s_rresp, arvalid_q, araddr_q, rready, wready, wr_addr, wdata});
   endfunction

   initial begin
      logic [1:0]  resp, eresp, resp2;
      logic [31:0] data, edata, sa, sd;
      int          lat, elat, pulses, epulses, lat2, pulses2, seen_rv;
      logic [31:0] a, d;
      logic [3:0]  s;
      int          g;

      //             wr  addr          data          strb  gap dly err resp  lat pls core
      tbl[0]  = '{1'b1, 32'h600,  32'h0000_00FF, 4'hF,  0, 0, 0, 2'b00, 2, 1, 0};
      tbl[1]  = '{1'b1, 32'h500,  32'h0000_0001, 4'hF,  3, 0, 0, 2'b00, 2, 1, 0};
      tbl[2]  = '{1'b1, 32'h700,  32'h0000_1234, 4'h3,  0, 0, 0, 2'b10, 1, 0, 0};
      tbl[3]  = '{1'b1, 32'hA00,  32'h0000_5678, 4'hF,  0, 0, 0, 2'b10, 1, 0, 0};
      tbl[4]  = '{1'b1, 32'h1000, 32'h1234_5678, 4'hF, -2, 0, 0, 2'b00, 2, 1, 0};
      tbl[5]  = '{1'b1, 32'hFFC,  32'h0000_0009, 4'hF,  1, 0, 0, 2'b10, 1, 0, 0};
      tbl[6]  = '{1'b0, 32'h804,  32'h0,         4'h0,  0, 1, 0, 2'b00, 3, 1, 1};
      tbl[7]  = '{1'b0, 32'h80C,  32'h0,         4'h0,  0, 1, 0, 2'b10, 1, 0, 0};
      tbl[8]  = '{1'b0, 32'h7FC,  32'h0,         4'h0,  0, 1, 0, 2'b10, 1, 0, 0};
      tbl[9]  = '{1'b0, 32'h800,  32'h0,         4'h0,  0, 4, 1, 2'b10, 6, 1, 1};
      tbl[10] = '{1'b0, 32'h808,  32'h0,         4'h0,  0, 16, 0, 2'b00, 18, 1, 1};
      tbl[11] = '{1'b0, 32'h808,  32'h0,         4'h0,  0, 17, 0, 2'b10, 18, 1, 0};
      tbl[12] = '{1'b0, 32'h803,  32'h0,         4'h0,  0, 1, 0, 2'b00, 3, 1, 1};
      tbl[13] = '{1'b0, 32'h804,  32'h0,         4'h0,  0, 0, 0, 2'b10, 18, 1, 0};

      // Reset state and first accept after release
      repeat (3) step();
      chk("reset_outputs_zero", all_outputs_or(), 32'd0);
      axi_rstn = 1'b1;
      step();
      chk("first_ready", {28'd0, s_arready, s_awready, s_wready, rready}, 32'hF);

      // Directed table
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].gap, 0, resp, lat, pulses, sa, sd);
            chk($sformatf("t%0d_bresp", i), 32'(resp), 32'(tbl[i].exp_resp));
            chk($sformatf("t%0d_blat", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("t%0d_wpulses", i), 32'(pulses), 32'(tbl[i].exp_pulses));
            if (tbl[i].exp_pulses > 0) begin
               chk($sformatf("t%0d_wr_addr", i), sa, tbl[i].addr);
               chk($sformatf("t%0d_wdata", i), sd, tbl[i].data);
            end
         end else begin
            core_delay = tbl[i].dly;
            core_err = tbl[i].err;
            salt = $urandom;
            do_read(tbl[i].addr, 0, resp, data, lat, pulses, sa);
            chk($sformatf("t%0d_rresp", i), 32'(resp), 32'(tbl[i].exp_resp));
            chk($sformatf("t%0d_rdata", i), data,
                tbl[i].use_core ? core_fn(tbl[i].addr & ~32'h3) : 32'h0);
            chk($sformatf("t%0d_rlat", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("t%0d_arpulses", i), 32'(pulses), 32'(tbl[i].exp_pulses));
            if (tbl[i].exp_pulses > 0)
               chk($sformatf("t%0d_araddr_q", i), sa, tbl[i].addr & ~32'h3);
            drain();
         end
      end

      // Backpressure: 10 cycles of held responses
      core_delay = 2; core_err = 1'b0; salt = 32'h0BAD_F00D;
      do_read(32'h808, 10, resp, data, lat, pulses, sa);
      chk("bp_rdata", data, core_fn(32'h808));
      chk("bp_rresp", 32'(resp), 32'd0);
      drain();
      do_write(32'h700, 32'hA5A5_0001, 4'hF, 0, 10, resp, lat, pulses, sa, sd);
      chk("bp_bresp", 32'(resp), 32'd0);
      chk("bp_wpulses", 32'(pulses), 32'd1);

      // Read and write in flight together
      core_delay = 3; salt = 32'h1357_9BDF;
      fork
         do_write(32'h1004, 32'hCAFE_0001, 4'hF, 1, 0, resp2, lat2, pulses2, sa, sd);
         do_read(32'h800, 0, resp, data, lat, pulses, a);
      join
      chk("conc_bresp", 32'(resp2), 32'd0);
      chk("conc_blat", 32'(lat2), 32'd2);
      chk("conc_wdata", sd, 32'hCAFE_0001);
      chk("conc_rdata", data, core_fn(32'h800));
      chk("conc_rlat", 32'(lat), 32'd5);
      drain();

      // Reset while waiting on the core
      core_delay = 0;
      s_araddr = 32'h800;
      s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      step();
      step();
      axi_rstn = 1'b0;
      step();
      chk("midreset_outputs_zero", all_outputs_or(), 32'd0);
      step();
      axi_rstn = 1'b1;
      step();
      chk("midreset_ready", {29'd0, s_arready, s_awready, s_wready}, 32'h7);
      seen_rv = 0;
      for (int k = 0; k < 24; k++) begin
         if (s_rvalid || s_bvalid || arvalid_q || wready) seen_rv++;
         step();
      end
      chk("midreset_no_stale", 32'(seen_rv), 32'd0);

      // Randomized traffic against the model
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            a = 32'h7F0 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
            core_delay = int'($urandom_range(0, 19));
            core_err = 1'($urandom_range(0, 1));
            salt = $urandom;
            rd_model(a, core_delay, core_err, eresp, edata, elat, epulses);
            do_read(a, int'($urandom_range(0, 2)), resp, data, lat, pulses, sa);
            chk($sformatf("rnd%0d_rresp", it), 32'(resp), 32'(eresp));
            chk($sformatf("rnd%0d_rdata", it), data, edata);
            chk($sformatf("rnd%0d_rlat", it), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_arpulses", it), 32'(pulses), 32'(epulses));
            drain();
         end else begin
            case ($urandom_range(0, 5))
               0: a = 32'h500;
               1: a = 32'h600;
               2: a = 32'h700;
               3: a = 32'h800;
               4: a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
               default: a = 32'($urandom_range(0, 32'h1FFF)) & ~32'h3;
            endcase
            s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            d = $urandom;
            g = int'($urandom_range(0, 6)) - 3;
            do_write(a, d, s, g, int'($urandom_range(0, 2)), resp, lat, pulses, sa, sd);
            if (wr_valid(a, s)) begin
               chk($sformatf("rnd%0d_bresp", it), 32'(resp), 32'd0);
               chk($sformatf("rnd%0d_blat", it), 32'(lat), 32'd2);
               chk($sformatf("rnd%0d_wpulses", it), 32'(pulses), 32'd1);
               chk($sformatf("rnd%0d_wr_addr", it), sa, a);
               chk($sformatf("rnd%0d_wdata", it), sd, d);
            end else begin
               chk($sformatf("rnd%0d_bresp", it), 32'(resp), 32'd2);
               chk($sformatf("rnd%0d_blat", it), 32'(lat), 32'd1);
               chk($sformatf("rnd%0d_wpulses", it), 32'(pulses), 32'd0);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
